// File: rtl/fp_1d5_mul_update_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_1d5_mul_update_pipe
// Purpose  : y1 = y0 * corr, 3-stage sign-less FP32 multiply with stall support.
//            Optional x pass-through pipeline enabled by macro FP_MUL_X_DELAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fp_1d5_mul_update_pipe #(
    parameter int EXP_W       = 8,
    parameter int MAN_W       = 23,
    parameter int ROUND_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid,
    input  logic                   backprn,
    input  logic [EXP_W+MAN_W-1:0] corr_in,
    input  logic [EXP_W+MAN_W-1:0] y_in,
    input  logic                   error_in,
`ifdef FP_MUL_X_DELAY_EN
    input  logic [EXP_W+MAN_W-1:0] x_in,
    output logic [EXP_W+MAN_W-1:0] x_out,
`endif
    output logic [EXP_W+MAN_W-1:0] float_out,
    output logic                   ready,
    output logic                   error_out
);

    localparam int c_W   = EXP_W + MAN_W;
    localparam int c_PW  = 2 * (MAN_W + 1);
    localparam int c_NW  = MAN_W + ROUND_SHIFT;
    localparam int c_KW  = c_NW + 2;
    localparam int c_EW  = EXP_W + 2;

    localparam logic signed [c_EW-1:0] c_BIAS = c_EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [c_EW-1:0] c_EMAX = c_EW'((1 << EXP_W) - 1);
    localparam logic signed [c_EW-1:0] c_ONE  = c_EW'(1);
    localparam logic signed [c_EW-1:0] c_ZERO = '0;

    // ---------------- stage 1: unpack / multiply ----------------
    logic [MAN_W:0]          w_ma, w_mb;
    logic [c_PW-1:0]         w_prod;
    logic signed [c_EW-1:0]  w_esum;
    logic                    w_pre_err;

    assign w_ma      = {1'b1, corr_in[MAN_W-1:0]};
    assign w_mb      = {1'b1, y_in[MAN_W-1:0]};
    assign w_prod    = {{(MAN_W+1){1'b0}}, w_ma} * {{(MAN_W+1){1'b0}}, w_mb};
    assign w_esum    = $signed({2'b00, corr_in[c_W-1:MAN_W]})
                     + $signed({2'b00, y_in[c_W-1:MAN_W]}) - c_BIAS;
    assign w_pre_err = (y_in[c_W-1:MAN_W] == '0) || (y_in[c_W-1:MAN_W] == '1);

    logic                    r1_valid, r1_err;
    logic [c_KW-1:0]         r1_prod;   // only the bits normalization can reach
    logic signed [c_EW-1:0]  r1_esum;

    // ---------------- stage 2: normalize ----------------
    logic [c_NW-1:0]         w_norm_man;
    logic signed [c_EW-1:0]  w_norm_exp;

    always_comb begin
        w_norm_man = r1_prod[c_NW-1:0];
        w_norm_exp = r1_esum;
        if (r1_prod[c_KW-1]) begin
            w_norm_man = r1_prod[c_KW-2 -: c_NW];
            w_norm_exp = r1_esum + c_ONE;
        end
    end

    logic                    r2_valid, r2_err;
    logic [c_NW-1:0]         r2_man;
    logic signed [c_EW-1:0]  r2_exp;

    // ---------------- stage 3: round half up / pack ----------------
    logic [MAN_W:0]          w_rnd;
    logic                    w_carry;
    logic [MAN_W-1:0]        w_fin_man;
    logic signed [c_EW-1:0]  w_fin_exp;
    logic                    w_ovf, w_unf;
    logic [c_W-1:0]          w_result;

    assign w_rnd     = {1'b0, r2_man[c_NW-1:ROUND_SHIFT]}
                     + {{MAN_W{1'b0}}, r2_man[ROUND_SHIFT-1]};
    assign w_carry   = w_rnd[MAN_W];
    assign w_fin_man = w_carry ? '0 : w_rnd[MAN_W-1:0];
    assign w_fin_exp = r2_exp + $signed({{(c_EW-1){1'b0}}, w_carry});
    assign w_ovf     = (w_fin_exp >= c_EMAX);
    assign w_unf     = (w_fin_exp <= c_ZERO);

    always_comb begin
        w_result = {w_fin_exp[EXP_W-1:0], w_fin_man};
        if (w_ovf)
            w_result = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_unf)
            w_result = '0;
    end

    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{w_prod[c_PW-c_KW-1:0], r2_man[ROUND_SHIFT-2:0]};

`ifdef FP_MUL_X_DELAY_EN
    logic [c_W-1:0] r1_x, r2_x;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r1_err    <= 1'b0;
            r1_prod   <= '0;
            r1_esum   <= '0;
            r2_valid  <= 1'b0;
            r2_err    <= 1'b0;
            r2_man    <= '0;
            r2_exp    <= '0;
            ready     <= 1'b0;
            error_out <= 1'b0;
            float_out <= '0;
`ifdef FP_MUL_X_DELAY_EN
            r1_x      <= '0;
            r2_x      <= '0;
            x_out     <= '0;
`endif
        end else if (backprn) begin
            r1_valid  <= valid;
            r1_err    <= error_in | w_pre_err;
            r1_prod   <= w_prod[c_PW-1 -: c_KW];
            r1_esum   <= w_esum;
            r2_valid  <= r1_valid;
            r2_err    <= r1_err;
            r2_man    <= w_norm_man;
            r2_exp    <= w_norm_exp;
            ready     <= r2_valid;
            // float_out keeps its last result across bubbles
            error_out <= r2_valid & (r2_err | w_ovf | w_unf);
            if (r2_valid)
                float_out <= w_result;
`ifdef FP_MUL_X_DELAY_EN
            r1_x      <= x_in;
            r2_x      <= r1_x;
            if (r2_valid)
                x_out <= r2_x;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_1d5_mul_update_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_1d5_mul_update_pipe
// Purpose  : directed + randomized checks of fp_1d5_mul_update_pipe against
//            an arithmetic reference model and a latency scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_1d5_mul_update_pipe;

    logic        clk = 1'b0;
    logic        rst, valid, backprn, error_in;
    logic [30:0] corr_in, y_in, float_out;
    logic        ready, error_out;
`ifdef FP_MUL_X_DELAY_EN
    logic [30:0] x_in, x_out;
`endif

    always #5 clk = ~clk;

    fp_1d5_mul_update_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .backprn   (backprn),
        .corr_in   (corr_in),
        .y_in      (y_in),
        .error_in  (error_in),
`ifdef FP_MUL_X_DELAY_EN
        .x_in      (x_in),
        .x_out     (x_out),
`endif
        .float_out (float_out),
        .ready     (ready),
        .error_out (error_out)
    );

    typedef struct {
        int          due;
        logic [30:0] f;
        logic        e;
        logic [30:0] x;
    } exp_t;

    exp_t        q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          adv    = 0;
    logic        exp_ready = 1'b0;
    logic        exp_err   = 1'b0;
    logic [30:0] exp_float = '0;
    logic [30:0] exp_x     = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Exact integer product, rounded half up at the 24-bit mantissa position.
    function automatic logic [31:0] ref_mul(input logic [30:0] c, input logic [30:0] y,
                                            input logic ei);
        longint unsigned ma, mb, p, m;
        int hi, sh, e;
        logic err;
        ma  = 64'(c[22:0]) | 64'h80_0000;
        mb  = 64'(y[22:0]) | 64'h80_0000;
        p   = ma * mb;
        hi  = int'(p >> 47);
        sh  = 23 + hi;
        m   = (p + (64'd1 << (sh - 1))) >> sh;
        e   = int'(c[30:23]) + int'(y[30:23]) - 127 + hi;
        if (m == 64'h100_0000) begin
            m = 64'h80_0000;
            e = e + 1;
        end
        err = ei || (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
        if (e >= 255)
            return {1'b1, 8'hFF, 23'h0};
        else if (e <= 0)
            return {1'b1, 31'h0};
        return {err, e[7:0], m[22:0]};
    endfunction

    task automatic step(input logic v, input logic b, input logic r,
                        input logic [30:0] c, input logic [30:0] y, input logic ei);
        logic [31:0] res;
        logic [30:0] xv;
        exp_t        it;
        xv       = 31'($urandom);
        valid    = v;
        backprn  = b;
        rst      = r;
        corr_in  = c;
        y_in     = y;
        error_in = ei;
`ifdef FP_MUL_X_DELAY_EN
        x_in     = xv;
`endif
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            exp_ready = 1'b0;
            exp_err   = 1'b0;
            exp_float = '0;
            exp_x     = '0;
        end else if (b) begin
            adv++;
            if (v) begin
                res  = ref_mul(c, y, ei);
                it   = '{due: adv + 2, f: res[30:0], e: res[31], x: xv};
                q.push_back(it);
            end
            if (q.size() > 0 && q[0].due == adv) begin
                exp_ready = 1'b1;
                exp_float = q[0].f;
                exp_err   = q[0].e;
                exp_x     = q[0].x;
                void'(q.pop_front());
            end else begin
                exp_ready = 1'b0;
                exp_err   = 1'b0;
            end
        end
        check("ready", {31'h0, ready}, {31'h0, exp_ready});
        check("float_out", {1'b0, float_out}, {1'b0, exp_float});
        check("error_out", {31'h0, error_out}, {31'h0, exp_err});
`ifdef FP_MUL_X_DELAY_EN
        check("x_out", {1'b0, x_out}, {1'b0, exp_x});
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b1, 1'b0, 31'h0, 31'h0, 1'b0);
    endtask

    function automatic logic [30:0] rand_y();
        logic [7:0] ex;
        int sel;
        sel = int'($urandom_range(0, 15));
        case (sel)
            0:       ex = 8'h00;
            1:       ex = 8'hFF;
            2, 3:    ex = 8'($urandom_range(1, 10));
            4:       ex = 8'($urandom_range(250, 254));
            default: ex = 8'($urandom_range(100, 160));
        endcase
        return {ex, 23'($urandom)};
    endfunction

    initial begin
        valid = 0; backprn = 1; rst = 1; error_in = 0; corr_in = '0; y_in = '0;
`ifdef FP_MUL_X_DELAY_EN
        x_in = '0;
`endif
        step(1'b0, 1'b1, 1'b1, 31'h0, 31'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 31'h0, 31'h0, 1'b0);

        // 1.0 * 2.0
        step(1'b1, 1'b1, 1'b0, 31'h3F800000, 31'h40000000, 1'b0);
        idle(4);
        // back-to-back
        step(1'b1, 1'b1, 1'b0, 31'h3FC00000, 31'h3FC00000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 31'h3F400000, 31'h3F000000, 1'b0);
        idle(4);
        // rounding, overflow, upstream error
        step(1'b1, 1'b1, 1'b0, 31'h3FC00001, 31'h3FC00000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 31'h3FFFFFFF, 31'h7F7FFFFF, 1'b0);
        step(1'b1, 1'b1, 1'b0, 31'h3F800000, 31'h40000000, 1'b1);
        idle(4);
        // stall mid-stream; input offered during the stall is dropped
        step(1'b1, 1'b1, 1'b0, 31'h3F800000, 31'h40400000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 31'h3F7FFFFF, 31'h40A00000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 31'h0, 31'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 31'h3F800000, 31'h3F800000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 31'h3F000000, 31'h41000000, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 31'h0, 31'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 31'h0, 31'h0, 1'b0);
        idle(3);
        // reset with two results in flight, then a fresh input
        step(1'b1, 1'b1, 1'b0, 31'h3FC00000, 31'h3FC00000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 31'h3F400000, 31'h3F000000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 31'h0, 31'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 31'h3F800000, 31'h40000000, 1'b0);
        idle(4);
        // underflow
        step(1'b1, 1'b1, 1'b0, 31'h3F000000, 31'h00800000, 1'b0);
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 299) == 0),
                 {7'h3F, 1'($urandom), 23'($urandom)}, rand_y(),
                 ($urandom_range(0, 7) == 0));
        end
        idle(5);
        check("drain", {31'h0, (q.size() == 0)}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
